ram_writer: RTL and testbench

Writable counterpart to the team's read-only 16×8 lookup memory. It accepts a byte stream over a valid/ready handshake and stores the bytes at sequential addresses 0..DEPTH-1 of an internal memory. A combinational read port (address in, data out) has the same shape as the ROM read port. The block sits where a lookup table must be loaded at run time instead of fixed at synthesis.

---
 rtl/ram_writer_pkg.sv | 21 ++
 rtl/ram_writer_mem.sv | 28 ++
 rtl/ram_writer.sv | 131 +++++++++++++
 tb/tb_ram_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_writer_pkg.sv
// ram_writer_pkg: shared types and constants for the run-time loadable
// lookup memory.
//   state_t    : write-side FSM states
//   *_DEF      : default word / address widths (16x8 memory)
//   init_word  : power-up pattern, odd numbers 1, 3, 5, ...
package ram_writer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_FILL,
    ST_FULL
  } state_t;

  function automatic int unsigned init_word(input int unsigned i);
    return 2 * i + 1;
  endfunction

endpackage

// File: rtl/ram_writer_mem.sv
// ram_writer_mem: DEPTH x DATA_W storage.
//   i_clk            : write clock
//   i_we/i_waddr/i_wdata : synchronous write port
//   i_raddr/o_rdata  : combinational read port (no write bypass)
// No reset: contents survive reset and are X until first written.
module ram_writer_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_writer.sv
// ram_writer: loads a byte stream over valid/ready into sequential addresses
// 0..DEPTH-1, read back through a combinational port.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_wr_data/i_wr_valid/o_wr_ready : write stream handshake
//   i_wr_clear     : restart the write pointer (memory retained)
//   i_rd_addr/o_rd_data : combinational read port
//   o_count        : words written since reset/clear (0..DEPTH)
//   o_full         : o_count == DEPTH
// Optional macro RAM_WRITER_AUTO_INIT_EN: after reset, fill memory with
// init_word(i) over DEPTH cycles before accepting writes.
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic              i_wr_clear,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wptr,  w_wptr_nxt;
  logic [ADDR_W:0]     r_count, w_count_nxt;
  logic                r_full,  w_full_nxt;
  logic                w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
`ifdef RAM_WRITER_AUTO_INIT_EN
      r_state <= ST_INIT;
`else
      r_state <= ST_FILL;
`endif
      r_wptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_count <= w_count_nxt;
      r_full  <= w_full_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_count_nxt = r_count;
    w_full_nxt  = r_full;
    w_we        = 1'b0;
    w_wdata     = i_wr_data;
    w_ready     = 1'b0;
    case (r_state)
`ifdef RAM_WRITER_AUTO_INIT_EN
      // wptr doubles as the init index; inputs are ignored here
      ST_INIT: begin
        w_we    = 1'b1;
        w_wdata = DATA_W'(init_word(32'(r_wptr)));
        if (r_wptr == LAST) begin
          w_state_nxt = ST_FILL;
          w_wptr_nxt  = '0;
        end else begin
          w_wptr_nxt  = r_wptr + PTR_ONE;
        end
      end
`endif
      ST_FILL: begin
        w_ready = 1'b1;
        if (i_wr_clear) begin
          // clear wins: a same-cycle handshake is dropped
          w_wptr_nxt  = '0;
          w_count_nxt = '0;
          w_full_nxt  = 1'b0;
        end else if (i_wr_valid) begin
          w_we        = 1'b1;
          w_count_nxt = r_count + CNT_ONE;
          if (r_wptr == LAST) begin
            // pointer parks at the last address rather than wrapping
            w_state_nxt = ST_FULL;
            w_count_nxt = CNT_MAX;
            w_full_nxt  = 1'b1;
          end else begin
            w_wptr_nxt  = r_wptr + PTR_ONE;
          end
        end
      end
      ST_FULL: begin
        if (i_wr_clear) begin
          w_state_nxt = ST_FILL;
          w_wptr_nxt  = '0;
          w_count_nxt = '0;
          w_full_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  ram_writer_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_wr_ready = w_ready;
  assign o_count    = r_count;
  assign o_full     = r_full;

endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: scoreboard bench for ram_writer (default 16x8).
// Expected memory words are queued as writes are driven and drained through
// the read port. Build with RAM_WRITER_AUTO_INIT_EN to cover the init phase.
module tb_ram_writer;

`ifdef RAM_WRITER_AUTO_INIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_clear;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;

  ram_writer dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_data  (wr_data),
    .i_wr_valid (wr_valid),
    .o_wr_ready (wr_ready),
    .i_wr_clear (wr_clear),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_count    (count),
    .o_full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] mdl [16];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [7:0] d);
    sb_t e;
    e.a = 4'(a);
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rd_addr = e.a;
      #1;
      chk($sformatf("mem[%0d]", e.a), 32'(rd_data), 32'(e.d));
    end
  endtask

  // Bounded wait for wr_ready after reset release; checks INIT length.
  task automatic wait_rdy(input int exp);
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("init_len", 32'(n), 32'(exp));
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    wr_clear = 1'b0;
    rd_addr  = '0;
    step();
    step();
    chk("rst_rdy", 32'(wr_ready), AUTO ? 32'd0 : 32'd1);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    wait_rdy(AUTO ? 16 : 0);

    // back-to-back fill of 0xA0..0xAF
    for (int i = 0; i < 16; i++) begin
      chk("fill_rdy", 32'(wr_ready), 32'd1);
      chk("fill_cnt", 32'(count), 32'(i));
      wr_data  = 8'hA0 + 8'(i);
      wr_valid = 1'b1;
      mdl[i]   = wr_data;
      push(i, wr_data);
      step();
    end
    wr_valid = 1'b0;
    chk("full_flag", 32'(full), 32'd1);
    chk("full_cnt", 32'(count), 32'd16);
    chk("full_rdy", 32'(wr_ready), 32'd0);
    rd_addr = 4'd5;
    #1;
    chk("rd5", 32'(rd_data), 32'hA5);
    drain();

    // writes in FULL are ignored
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    repeat (4) begin
      step();
      chk("ign_cnt", 32'(count), 32'd16);
      chk("ign_rdy", 32'(wr_ready), 32'd0);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 16; i++) push(i, mdl[i]);
    drain();

    // clear from FULL, then 3 writes
    step();
    wr_clear = 1'b1;
    step();
    wr_clear = 1'b0;
    chk("clr_cnt", 32'(count), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    chk("clr_rdy", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wr_data  = 8'h10 + 8'(i);
      wr_valid = 1'b1;
      mdl[i]   = wr_data;
      push(i, wr_data);
      step();
    end
    wr_valid = 1'b0;
    chk("cnt3", 32'(count), 32'd3);

    // clear beats a simultaneous handshake
    wr_clear = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    step();
    wr_clear = 1'b0;
    wr_valid = 1'b0;
    chk("clrw_cnt", 32'(count), 32'd0);
    drain();
    step();
    wr_data  = 8'h66;
    wr_valid = 1'b1;
    mdl[0]   = 8'h66;
    push(0, 8'h66);
    push(1, mdl[1]);
    step();
    wr_valid = 1'b0;
    chk("after_clr_cnt", 32'(count), 32'd1);
    drain();

    // same-cycle read sees old data, new data after the edge
    step();
    wr_clear = 1'b1;
    step();
    wr_clear = 1'b0;
    rd_addr  = 4'd0;
    wr_data  = 8'h12;
    wr_valid = 1'b1;
    #1;
    chk("rd_old", 32'(rd_data), 32'h66);
    step();
    wr_valid = 1'b0;
    chk("rd_new", 32'(rd_data), 32'h12);
    step();
    chk("idle_cnt", 32'(count), 32'd1);

    // reset mid-fill discards progress
    rst_n = 1'b0;
    step();
    chk("rst2_cnt", 32'(count), 32'd0);
    chk("rst2_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    wait_rdy(AUTO ? 16 : 0);
`ifdef RAM_WRITER_AUTO_INIT_EN
    push(15, 8'd31);
    push(0, 8'd1);
    push(7, 8'd15);
    drain();
    // reset at INIT cycle 7 restarts INIT
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (7) step();
    chk("init_mid_rdy", 32'(wr_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_rdy(16);
    push(15, 8'd31);
    push(0, 8'd1);
    drain();
`else
    // memory is untouched by reset
    push(0, 8'h12);
    push(2, mdl[2]);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
